// File: rtl/shift_issue_unit.sv
// rtl/shift_issue_unit.sv - buffered issue/retire stage around a 32-bit five-mode barrel shifter
// Optional SHIFT_ISSUE_STATS_EN adds saturating stat_ops / stat_stall counters.
module shift_issue_unit #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic [4:0]        in_amount,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_carry,
  output logic              out_zero,
  output logic              out_illegal
`ifdef SHIFT_ISSUE_STATS_EN
  ,
  output logic [31:0]       stat_ops,
  output logic [31:0]       stat_stall
`endif
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = $clog2(DEPTH + 1);

  generate
    if (DATA_W != 32) begin : gDataWidthCheck
      $error("shift_issue_unit: DATA_W must be 32");
    end
    if (DEPTH < 2 || DEPTH > 8) begin : gDepthCheck
      $error("shift_issue_unit: DEPTH must be 2..8");
    end
  endgenerate

  logic [2:0]        qMode [DEPTH];
  logic [DATA_W-1:0] qData [DEPTH];
  logic [4:0]        qAmount [DEPTH];
  logic [PtrW-1:0]   wrPtr, rdPtr;
  logic [CntW-1:0]   count;

  logic accept, retire, load;
  logic [2:0]        headMode;
  logic [DATA_W-1:0] headData;
  logic [4:0]        headAmount;
  logic [DATA_W-1:0] calcResult;
  logic              calcCarry, calcIllegal;
  logic [2*DATA_W-1:0] rotWide;
  logic [5:0]        sllIdx;

  function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready = (count < CntW'(DEPTH));
  assign accept   = in_valid & in_ready;
  assign retire   = out_valid & out_ready;
  // Head moves into the result register whenever that register is free or being drained.
  assign load     = (!out_valid || out_ready) && (count != '0);

  assign headMode   = qMode[rdPtr];
  assign headData   = qData[rdPtr];
  assign headAmount = qAmount[rdPtr];

  always_ff @(posedge clock) begin
    if (accept && !flush) begin
      qMode[wrPtr]   <= in_mode;
      qData[wrPtr]   <= in_data;
      qAmount[wrPtr] <= in_amount;
    end
  end

  always_comb begin
    calcResult  = '0;
    calcCarry   = 1'b0;
    calcIllegal = 1'b0;
    rotWide     = '0;
    sllIdx      = 6'd32 - {1'b0, headAmount};
    case (headMode)
      3'd0: begin
        calcResult = headData << headAmount;
        calcCarry  = (headAmount != 5'd0) && headData[sllIdx[4:0]];
      end
      3'd1: begin
        rotWide    = {headData, headData} << headAmount;
        calcResult = rotWide[2*DATA_W-1:DATA_W];
        calcCarry  = (headAmount != 5'd0) && calcResult[0];
      end
      3'd2: begin
        calcResult = headData >> headAmount;
        calcCarry  = (headAmount != 5'd0) && headData[headAmount - 5'd1];
      end
      3'd3: begin
        calcResult = $signed(headData) >>> headAmount;
        calcCarry  = (headAmount != 5'd0) && headData[headAmount - 5'd1];
      end
      3'd4: begin
        rotWide    = {headData, headData} >> headAmount;
        calcResult = rotWide[DATA_W-1:0];
        calcCarry  = (headAmount != 5'd0) && calcResult[DATA_W-1];
      end
      default: calcIllegal = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_carry   <= 1'b0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) wrPtr <= nextPtr(wrPtr);
      if (load)   rdPtr <= nextPtr(rdPtr);
      case ({accept, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (load) begin
        out_valid   <= 1'b1;
        out_result  <= calcResult;
        out_carry   <= calcCarry;
        out_zero    <= (calcResult == '0);
        out_illegal <= calcIllegal;
      end else if (retire) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SHIFT_ISSUE_STATS_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (retire && !flush && stat_ops != 32'hFFFF_FFFF) stat_ops <= stat_ops + 1'b1;
      if (out_valid && !out_ready && stat_stall != 32'hFFFF_FFFF) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule
